// File: rtl/conv_host_pkg.sv
// Shared types and constants for the CONV memory host.
// Bank select and FSM encodings, default bank depths, and the
// address range check used on every layer and debug access.
package conv_host_pkg;

  typedef enum logic [2:0] {
    NONE = 3'b000,
    L0_0 = 3'b001,
    L0_1 = 3'b010,
    L1_0 = 3'b011,
    L1_1 = 3'b100,
    L2   = 3'b101
  } csel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned IMG_DEPTH_C = 4096;
  localparam int unsigned L0_DEPTH_C  = 4096;
  localparam int unsigned L1_DEPTH_C  = 1024;
  localparam int unsigned L2_DEPTH_C  = 2048;

  // True when sel names a real layer bank and addr lies inside it.
  function automatic logic in_range(input csel_e       sel,
                                    input int unsigned addr,
                                    input int unsigned l0_depth = L0_DEPTH_C,
                                    input int unsigned l1_depth = L1_DEPTH_C,
                                    input int unsigned l2_depth = L2_DEPTH_C);
    case (sel)
      L0_0, L0_1: return addr < l0_depth;
      L1_0, L1_1: return addr < l1_depth;
      L2:         return addr < l2_depth;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Single-write, dual-read memory bank.
// Write is synchronous; both reads are asynchronous, so a read of the
// address being written in the same cycle returns the old word.
module conv_bank_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned DW    = 20
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_a_i,
  output logic [DW-1:0]            rdata_a_o,
  input  logic [$clog2(DEPTH)-1:0] raddr_b_i,
  output logic [DW-1:0]            rdata_b_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/conv_mem_host.sv
// Memory-side responder for the CONV accelerator: image ROM, five layer
// banks, ready/busy start handshake, completion and sticky error flag,
// plus a debug readback port.
// Optional feature macro: CONV_HOST_TIMEOUT_EN (RUN watchdog, TIMEOUT param).
module conv_mem_host
  import conv_host_pkg::*;
#(
  parameter int unsigned DW       = 20,
  parameter int unsigned AW       = 12,
  parameter int unsigned L1_DEPTH = L1_DEPTH_C,
  parameter int unsigned L2_DEPTH = L2_DEPTH_C
`ifdef CONV_HOST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 65535
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          err,
  input  logic [2:0]    dbg_sel,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned L0_DEPTH = 2 ** AW;

  state_e        state_q;
  logic          ready_q;
  logic          done_q;
  logic          err_q;
`ifdef CONV_HOST_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0]   wd_q;
`endif

  csel_e         sel;
  csel_e         dsel;
  logic          csel_ok;
  logic          wr_ok;
  logic          rd_ok;
  logic          acc_err;
  logic          img_we;
  logic [DW-1:0] img_dbg;
  logic [4:0]    bank_we;
  logic [DW-1:0] bank_rd  [5];
  logic [DW-1:0] bank_dbg [5];

  assign sel     = csel_e'(csel);
  assign dsel    = csel_e'(dbg_sel);
  assign csel_ok = (csel >= 3'd1) && (csel <= 3'd5);
  assign wr_ok   = in_range(sel, 32'(caddr_wr), L0_DEPTH, L1_DEPTH, L2_DEPTH);
  assign rd_ok   = in_range(sel, 32'(caddr_rd), L0_DEPTH, L1_DEPTH, L2_DEPTH);

  // Dropped writes (bad select or range), out-of-range reads on a real
  // bank, and any layer access outside START/RUN all raise err.
  assign acc_err = (cwr && !wr_ok)
                || (crd && csel_ok && !rd_ok)
                || ((cwr || crd) && (state_q == IDLE || state_q == DONE));

  assign img_we = ld_en && (state_q == IDLE);

  conv_bank_ram #(.DEPTH(L0_DEPTH), .DW(DW)) u_img (
    .clk_i     (clk),
    .we_i      (img_we),
    .waddr_i   (ld_addr),
    .wdata_i   (ld_data),
    .raddr_a_i (iaddr),
    .rdata_a_o (idata),
    .raddr_b_i (dbg_addr),
    .rdata_b_o (img_dbg)
  );

  for (genvar b = 0; b < 5; b++) begin : g_layer
    localparam int unsigned D  = (b < 2) ? L0_DEPTH : (b < 4) ? L1_DEPTH : L2_DEPTH;
    localparam int unsigned BW = $clog2(D);
    assign bank_we[b] = cwr && wr_ok && (csel == 3'(b + 1));
    conv_bank_ram #(.DEPTH(D), .DW(DW)) u_bank (
      .clk_i     (clk),
      .we_i      (bank_we[b]),
      .waddr_i   (caddr_wr[BW-1:0]),
      .wdata_i   (cdata_wr),
      .raddr_a_i (caddr_rd[BW-1:0]),
      .rdata_a_o (bank_rd[b]),
      .raddr_b_i (dbg_addr[BW-1:0]),
      .rdata_b_o (bank_dbg[b])
    );
  end

  // Layer read mux; zero when not reading, bad select or out of range.
  always_comb begin
    cdata_rd = '0;
    if (crd && rd_ok) begin
      case (sel)
        L0_0:    cdata_rd = bank_rd[0];
        L0_1:    cdata_rd = bank_rd[1];
        L1_0:    cdata_rd = bank_rd[2];
        L1_1:    cdata_rd = bank_rd[3];
        L2:      cdata_rd = bank_rd[4];
        default: cdata_rd = '0;
      endcase
    end
  end

  // Debug readback; select 000 returns the image so a load can be verified.
  always_comb begin
    dbg_data = '0;
    if (dsel == NONE) begin
      dbg_data = img_dbg;
    end else if (in_range(dsel, 32'(dbg_addr), L0_DEPTH, L1_DEPTH, L2_DEPTH)) begin
      case (dsel)
        L0_0:    dbg_data = bank_dbg[0];
        L0_1:    dbg_data = bank_dbg[1];
        L1_0:    dbg_data = bank_dbg[2];
        L1_1:    dbg_data = bank_dbg[3];
        L2:      dbg_data = bank_dbg[4];
        default: dbg_data = '0;
      endcase
    end
  end

  // Start handshake, completion level and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONV_HOST_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      if (acc_err) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= START;
            ready_q <= 1'b1;
            // START entry clears err, but an error on this same edge still wins
            err_q   <= acc_err;
          end
        end
        START: begin
          if (busy) begin
            state_q <= RUN;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
`ifdef CONV_HOST_TIMEOUT_EN
          if (!busy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            wd_q    <= '0;
          end else if (wd_q == WD_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            wd_q    <= '0;
          end else begin
            wd_q    <= wd_q + 16'd1;
          end
`else
          if (!busy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (start) begin
            state_q <= START;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= acc_err;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: scoreboarded memory readbacks
// plus direct checks of the handshake, error and reset behaviour.
module tb_conv_mem_host;

  localparam int unsigned DW = 20;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          start;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          done;
  logic          err;
  logic [2:0]    dbg_sel;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

`ifdef CONV_HOST_TIMEOUT_EN
  conv_mem_host #(.TIMEOUT(100)) dut (
`else
  conv_mem_host dut (
`endif
    .clk      (clk),
    .reset    (reset),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .start    (start),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .done     (done),
    .err      (err),
    .dbg_sel  (dbg_sel),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  string         tag_q [$];
  logic [DW-1:0] exp_q [$];

  logic [2:0]    t_sel  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [AW-1:0] t_addr [10] = '{12'd5, 12'd5, 12'd5, 12'd5, 12'd5,
                                 12'd4095, 12'd0, 12'd0, 12'd1023, 12'd2047};
  logic [DW-1:0] t_data [10] = '{20'h10005, 20'h20005, 20'h30005, 20'h40005, 20'h50005,
                                 20'h1FFFF, 20'h20000, 20'h0AAAA, 20'h43FF0, 20'h57FF0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [DW-1:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [DW-1:0] got);
    string         t;
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, 32'(got), 32'(e));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wr_layer(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
    @(negedge clk);
    cwr = 1'b0;
  endtask

  task automatic rd_img(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
    @(negedge clk);
    iaddr = a;
    sb_push(tag, e);
    #1;
    sb_pop(idata);
  endtask

  // crd is held only between a falling edge and the next rising edge
  task automatic rd_layer(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] e,
                          input string tag);
    @(negedge clk);
    crd = 1'b1; csel = s; caddr_rd = a;
    sb_push(tag, e);
    #1;
    sb_pop(cdata_rd);
    crd = 1'b0;
  endtask

  task automatic rd_dbg(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] e,
                        input string tag);
    @(negedge clk);
    dbg_sel = s; dbg_addr = a;
    sb_push(tag, e);
    #1;
    sb_pop(dbg_data);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
    crd = 1'b0; caddr_rd = '0; csel = '0;
    dbg_sel = '0; dbg_addr = '0;

    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Image load in IDLE, zero-latency readback
    load(12'd0, 20'h00A00);
    rd_img(12'd0, 20'h00A00, "img0");
    load(12'd2, 20'h00002);
    load(12'd4095, 20'hFFFFF);
    rd_img(12'd2, 20'h00002, "img2");
    rd_img(12'd4095, 20'hFFFFF, "img4095");
    chk("idle_err", 32'(err), 32'd0);

    // Handshake: ready for exactly one cycle when busy follows it
    do_start();
    chk("ready_up", 32'(ready), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    @(negedge clk);
    busy = 1'b1;
    tick();
    chk("ready_1cyc", 32'(ready), 32'd0);

    // RUN: write then read back next cycle
    wr_layer(3'd3, 12'd5, 20'h12345);
    rd_layer(3'd3, 12'd5, 20'h12345, "l1_0_wr_rd");
    chk("wr_rd_err", 32'(err), 32'd0);

    // Image loads are ignored outside IDLE
    load(12'd2, 20'hBBBBB);
    rd_img(12'd2, 20'h00002, "ld_ignored");

    // All banks including the top valid address of each
    for (int i = 0; i < 10; i++) wr_layer(t_sel[i], t_addr[i], t_data[i]);
    for (int i = 0; i < 10; i++)
      rd_layer(t_sel[i], t_addr[i], t_data[i], $sformatf("rd_s%0d_a%0d", t_sel[i], t_addr[i]));
    for (int i = 0; i < 10; i++)
      rd_dbg(t_sel[i], t_addr[i], t_data[i], $sformatf("dbg_s%0d_a%0d", t_sel[i], t_addr[i]));
    chk("inrange_err", 32'(err), 32'd0);

    // Same-cycle read and write of one address returns the old word
    @(negedge clk);
    cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd5; cdata_wr = 20'h54321;
    crd = 1'b1; caddr_rd = 12'd5;
    sb_push("rw_old", 20'h30005);
    #1;
    sb_pop(cdata_rd);
    tick();
    cwr = 1'b0;
    sb_push("rw_new", 20'h54321);
    sb_pop(cdata_rd);
    crd = 1'b0;
    t_data[2] = 20'h54321;

    @(negedge clk);
    csel = 3'd3; caddr_rd = 12'd5;
    sb_push("crd_off_zero", '0);
    #1;
    sb_pop(cdata_rd);

    // Invalid select: no bank changes, err set
    wr_layer(3'd7, 12'd5, 20'hFFFFF);
    chk("bad_csel_err", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++)
      rd_dbg(t_sel[i], t_addr[i], t_data[i], $sformatf("bad_csel_keep_s%0d", t_sel[i]));
    rd_layer(3'd7, 12'd5, '0, "bad_csel_rd");

    // Completion, err stays sticky
    @(negedge clk);
    busy = 1'b0;
    tick();
    chk("done_up", 32'(done), 32'd1);
    chk("done_ready", 32'(ready), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);

    // Restart from DONE clears done and err
    do_start();
    chk("restart_ready", 32'(ready), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_err", 32'(err), 32'd0);
    @(negedge clk);
    busy = 1'b1;
    tick();

    // Out-of-range accesses
    wr_layer(3'd3, 12'd1024, 20'h77777);
    chk("oor_wr_err", 32'(err), 32'd1);
    rd_dbg(3'd3, 12'd0, 20'h0AAAA, "oor_wr_dropped");
    rd_layer(3'd3, 12'd1024, '0, "l1_oor_rd");
    rd_layer(3'd5, 12'd2048, '0, "l2_oor_rd");
    rd_layer(3'd5, 12'd2047, 20'h57FF0, "l2_top_rd");

    // Reset mid-RUN: outputs clear asynchronously, memories kept
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_run_done", 32'(done), 32'd0);
    chk("rst_run_err", 32'(err), 32'd0);
    chk("rst_run_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    busy = 1'b0;
    load(12'd1, 20'hC0DE1);
    rd_img(12'd1, 20'hC0DE1, "idle_after_rst");
    rd_dbg(3'd1, 12'd5, 20'h10005, "l0_0_kept_5");
    rd_dbg(3'd1, 12'd4095, 20'h1FFFF, "l0_0_kept_top");

    // Clean run, then a layer access while in DONE
    do_start();
    @(negedge clk);
    busy = 1'b1;
    tick();
    @(negedge clk);
    busy = 1'b0;
    tick();
    chk("run2_done", 32'(done), 32'd1);
    chk("run2_err", 32'(err), 32'd0);
    @(negedge clk);
    crd = 1'b1; csel = 3'd3; caddr_rd = 12'd5;
    @(negedge clk);
    crd = 1'b0;
    chk("done_access_err", 32'(err), 32'd1);

    // ready drops as soon as reset rises, not on a clock edge
    do_start();
    chk("pre_rst_ready", 32'(ready), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef CONV_HOST_TIMEOUT_EN
    begin
      int unsigned cycles;
      do_start();
      @(negedge clk);
      busy = 1'b1;
      tick();
      cycles = 0;
      while (!done && cycles < 300) begin
        tick();
        cycles++;
      end
      chk("wd_cycles", cycles, 32'd100);
      chk("wd_done", 32'(done), 32'd1);
      chk("wd_err", 32'(err), 32'd1);
      @(negedge clk);
      busy = 1'b0;
    end
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
